// File: rtl/comparator_pkg.sv
// Shared width, result encoding and flag helpers for the registered 4-bit comparator.
package comparator_pkg;

   localparam int unsigned CMP_WIDTH = 4;

   typedef enum logic [1:0] {
      CMP_LT,
      CMP_EQ,
      CMP_GT
   } cmp_result_t;

   // Flag vector ordering is {x, y, z} = {gt, eq, lt}.
   localparam logic [2:0] CMP_RESET_FLAGS = 3'b000;

   function automatic logic [2:0] result_to_flags(input cmp_result_t res);
      logic [2:0] flags;
      flags = 3'b010;
      case (res)
         CMP_GT:  flags = 3'b100;
         CMP_LT:  flags = 3'b001;
         default: flags = 3'b010;
      endcase
      return flags;
   endfunction

endpackage

// File: rtl/comparator_4bit_reg_if.sv
// Operand, cascade and result bundle for comparator_4bit_reg.
// Handshake: a sample is taken on every rising clk edge with in_valid = 1; out_valid is
// high for exactly the cycle after each such edge, and x/y/z hold between samples.
interface comparator_4bit_reg_if;
   logic in_valid;
   logic signed_mode;
   logic a3, a2, a1, a0;
   logic b3, b2, b1, b0;
   logic gt_in, eq_in, lt_in;
   logic x, y, z;
   logic out_valid;

   modport master (
      output in_valid, signed_mode,
      output a3, a2, a1, a0,
      output b3, b2, b1, b0,
      output gt_in, eq_in, lt_in,
      input  x, y, z, out_valid
   );

   modport slave (
      input  in_valid, signed_mode,
      input  a3, a2, a1, a0,
      input  b3, b2, b1, b0,
      input  gt_in, eq_in, lt_in,
      output x, y, z, out_valid
   );
endinterface

// File: rtl/comparator_bit_slice.sv
// Per-bit equal/greater/less terms; the signed-MSB option swaps the greater/less sense for a sign bit.
module comparator_bit_slice (
   input  logic a_i,
   input  logic b_i,
   input  logic signed_msb_i,
   output logic e_o,
   output logic g_o,
   output logic l_o
);

   assign e_o = ~(a_i ^ b_i);
   assign g_o = signed_msb_i ? (~a_i & b_i) : (a_i & ~b_i);
   assign l_o = signed_msb_i ? (a_i & ~b_i) : (~a_i & b_i);

endmodule

// File: rtl/comparator_4bit_reg.sv
// Registered 4-bit magnitude comparator with 74x85-style cascade inputs and a valid strobe.
module comparator_4bit_reg
   import comparator_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   comparator_4bit_reg_if.slave        bus
);

   logic [CMP_WIDTH-1:0] a_v, b_v;
   logic [CMP_WIDTH-1:0] e, g, l;
   logic                 gt_loc, lt_loc, eq_loc;
   cmp_result_t          casc_res, result;
   logic [2:0]           flags_d, flags_q;
   logic                 out_valid_d, out_valid_q;

   assign a_v = {bus.a3, bus.a2, bus.a1, bus.a0};
   assign b_v = {bus.b3, bus.b2, bus.b1, bus.b0};

   for (genvar i = 0; i < CMP_WIDTH; i++) begin : g_slice
      comparator_bit_slice u_slice (
         .a_i          (a_v[i]),
         .b_i          (b_v[i]),
         .signed_msb_i ((i == CMP_WIDTH - 1) && bus.signed_mode),
         .e_o          (e[i]),
         .g_o          (g[i]),
         .l_o          (l[i])
      );
   end

   always_comb begin
      gt_loc = g[3] | (e[3] & g[2]) | (e[3] & e[2] & g[1]) | (e[3] & e[2] & e[1] & g[0]);
      lt_loc = l[3] | (e[3] & l[2]) | (e[3] & e[2] & l[1]) | (e[3] & e[2] & e[1] & l[0]);
      eq_loc = &e;

      // Non-one-hot cascade: eq_in wins, then gt_in over lt_in; nothing set reads as equal.
      if (bus.eq_in)      casc_res = CMP_EQ;
      else if (bus.gt_in) casc_res = CMP_GT;
      else if (bus.lt_in) casc_res = CMP_LT;
      else                casc_res = CMP_EQ;

      if (eq_loc)      result = casc_res;
      else if (gt_loc) result = CMP_GT;
      else             result = CMP_LT;

      flags_d     = bus.in_valid ? result_to_flags(result) : flags_q;
      out_valid_d = bus.in_valid;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_q     <= CMP_RESET_FLAGS;
         out_valid_q <= 1'b0;
      end else begin
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.x         = flags_q[2];
   assign bus.y         = flags_q[1];
   assign bus.z         = flags_q[0];
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_comparator_4bit_reg.sv
// Directed and exhaustive checks of comparator_4bit_reg against hand-computed and integer-model results.
module tb_comparator_4bit_reg;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  comparator_4bit_reg_if cif ();

  comparator_4bit_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic sm,
                       input logic [2:0] casc, input logic v);
    @(negedge clk);
    cif.in_valid    = v;
    cif.signed_mode = sm;
    {cif.a3, cif.a2, cif.a1, cif.a0} = a;
    {cif.b3, cif.b2, cif.b1, cif.b0} = b;
    {cif.gt_in, cif.eq_in, cif.lt_in} = casc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [2:0] exp_flags, input logic exp_valid);
    logic [3:0] obs;
    logic [3:0] exp;
    obs = {cif.x, cif.y, cif.z, cif.out_valid};
    exp = {exp_flags, exp_valid};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed xyz/valid=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model(input logic [3:0] a, input logic [3:0] b, input logic sm);
    int ai;
    int bi;
    ai = int'(a);
    bi = int'(b);
    if (sm && a[3]) ai = ai - 16;
    if (sm && b[3]) bi = bi - 16;
    if (ai > bi)       return 3'b100;
    else if (ai == bi) return 3'b010;
    else               return 3'b001;
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    cif.in_valid = 1'b0;
    cif.signed_mode = 1'b0;
    {cif.a3, cif.a2, cif.a1, cif.a0} = 4'b0000;
    {cif.b3, cif.b2, cif.b1, cif.b0} = 4'b0000;
    {cif.gt_in, cif.eq_in, cif.lt_in} = 3'b010;

    #2;
    check("reset_no_clock", 3'b000, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    check("release_idle", 3'b000, 1'b0);

    // unsigned directed vectors, back to back
    drive(4'b0000, 4'b0000, 1'b0, 3'b010, 1'b1); step(); check("u_0000_0000", 3'b010, 1'b1);
    drive(4'b0101, 4'b0011, 1'b0, 3'b010, 1'b1); step(); check("u_0101_0011", 3'b100, 1'b1);
    drive(4'b0010, 4'b1010, 1'b0, 3'b010, 1'b1); step(); check("u_0010_1010", 3'b001, 1'b1);
    drive(4'b1100, 4'b1010, 1'b0, 3'b010, 1'b1); step(); check("u_1100_1010", 3'b100, 1'b1);
    drive(4'b0111, 4'b0111, 1'b0, 3'b010, 1'b1); step(); check("u_0111_0111", 3'b010, 1'b1);

    // signed vs unsigned on the same operands
    drive(4'b1100, 4'b0010, 1'b1, 3'b010, 1'b1); step(); check("s_m4_vs_p2", 3'b001, 1'b1);
    drive(4'b1100, 4'b0010, 1'b0, 3'b010, 1'b1); step(); check("u_12_vs_2", 3'b100, 1'b1);
    drive(4'b0111, 4'b1000, 1'b1, 3'b010, 1'b1); step(); check("s_p7_vs_m8", 3'b100, 1'b1);

    // cascade inputs on equal operands
    drive(4'b1001, 4'b1001, 1'b0, 3'b100, 1'b1); step(); check("casc_gt", 3'b100, 1'b1);
    drive(4'b1001, 4'b1001, 1'b0, 3'b001, 1'b1); step(); check("casc_lt", 3'b001, 1'b1);
    drive(4'b1001, 4'b1001, 1'b0, 3'b000, 1'b1); step(); check("casc_none", 3'b010, 1'b1);
    drive(4'b1001, 4'b1001, 1'b0, 3'b101, 1'b1); step(); check("casc_gt_lt", 3'b100, 1'b1);
    drive(4'b1001, 4'b1001, 1'b0, 3'b110, 1'b1); step(); check("casc_gt_eq", 3'b010, 1'b1);
    drive(4'b0110, 4'b1001, 1'b0, 3'b100, 1'b1); step(); check("casc_ignored", 3'b001, 1'b1);

    // hold when in_valid is low
    drive(4'b0101, 4'b0011, 1'b0, 3'b010, 1'b1); step(); check("hold_load", 3'b100, 1'b1);
    drive(4'b0001, 4'b1110, 1'b0, 3'b010, 1'b0); step(); check("hold_keep", 3'b100, 1'b0);
    step(); check("hold_keep2", 3'b100, 1'b0);

    // asynchronous reset mid-stream
    drive(4'b0010, 4'b0100, 1'b0, 3'b010, 1'b1); step(); check("pre_reset", 3'b001, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 3'b000, 1'b0);
    drive(4'b1111, 4'b0000, 1'b0, 3'b010, 1'b0);
    rst = 1'b0;
    step(); check("post_reset_idle", 3'b000, 1'b0);
    drive(4'b1111, 4'b0000, 1'b0, 3'b010, 1'b1); step(); check("post_reset_first", 3'b100, 1'b1);

    // exhaustive sweep, both modes
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 256; i++) begin
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] ab;
        ab = 8'(i);
        a = ab[7:4];
        b = ab[3:0];
        drive(a, b, m[0], 3'b010, 1'b1);
        step();
        check($sformatf("exh_m%0d_a%h_b%h", m, a, b), model(a, b, m[0]), 1'b1);
        tests++;
        assert ($onehot({cif.x, cif.y, cif.z})) else begin
          fails++;
          $error("FAIL onehot_m%0d_a%h_b%h observed=%b expected one-hot", m, a, b,
                 {cif.x, cif.y, cif.z});
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/comparator_4bit_reg.md
# comparator_4bit_reg

Registered 4-bit magnitude comparator producing one-hot greater/equal/less flags for two operands presented as individual bits. It sits in the datapath wherever a small unsigned or signed magnitude decision is needed, and supports 74x85-style cascading for wider compares. Inputs are sampled on a qualified clock edge, and the flags appear one cycle later with a valid strobe.

## Interface
- No parameters; operand width is fixed at 4.
- clk  in  1  single clock, rising-edge active.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  samples operands and cascade inputs on this clock edge.
- signed_mode  in  1  0 = unsigned compare; 1 = two's-complement compare (a3/b3 are sign bits).
- a3, a2, a1, a0  in  1 each  operand A, a3 = MSB.
- b3, b2, b1, b0  in  1 each  operand B, b3 = MSB.
- gt_in, eq_in, lt_in  in  1 each  cascade flags from the less-significant stage; a standalone stage ties them to 0/1/0.
- x  out  1  A > B.
- y  out  1  A == B.
- z  out  1  A < B.
- out_valid  out  1  x/y/z were updated on the previous edge.

## Operation
- A = {a3,a2,a1,a0}, B = {b3,b2,b1,b0}.
- Per-bit terms: e_i = ~(a_i ^ b_i), g_i = a_i & ~b_i, l_i = ~a_i & b_i.
- Unsigned compare:
  - gt = g3 | e3&g2 | e3&e2&g1 | e3&e2&e1&g0
  - lt = same form using l_i
  - eq = e3&e2&e1&e0
- Signed compare: MSB terms are swapped (g3 = ~a3 & b3, l3 = a3 & ~b3); lower bits are unchanged.
- Cascade, applied only when eq = 1: x = gt_in, y = eq_in, z = lt_in. Otherwise the outputs take the local gt/eq/lt.
- Cascade sanitising: if the cascade inputs are not one-hot, eq_in has priority. Otherwise gt_in has priority over lt_in. If none of the three is set, the stage reports equal.
- Outputs are always exactly one-hot after the first valid sample.
- When in_valid = 0, x/y/z hold their previous values.

## Timing
- Latency is 1 cycle. Operands sampled at edge N appear on x/y/z and out_valid at edge N (registered) and are stable through cycle N+1.
- out_valid is in_valid delayed by one register. It is high for exactly the cycles following sampled edges. Back-to-back in_valid gives one result per cycle with no bubbles.
- Reset (asynchronous, active-high): x = 0, y = 0, z = 0, out_valid = 0 immediately, independent of clk.
- Reset mid-stream: any pending result is discarded. The first result after release comes from the first in_valid edge after rst deasserts.
- No combinational path from any input to any output.

## Structure
- Shared package comparator_pkg holds:
  - constant CMP_WIDTH = 4
  - enum cmp_result_t {CMP_LT, CMP_EQ, CMP_GT}
  - constant CMP_RESET_FLAGS = 3'b000
- One sub-module is natural: comparator_bit_slice, which computes e_i/g_i/l_i for one bit with a signed-MSB option. Four instances are chained by the top-level priority logic.
- The top level contains the priority chain, the cascade mux, the sanitiser, and the output and valid registers.

## Test plan
- Reset: assert rst with no clock edge -> x/y/z/out_valid = 0 immediately. Deassert rst with in_valid = 0 -> outputs stay 0.
- Unsigned directed vectors, signed_mode = 0, cascade 0/1/0, one per cycle, each checked one edge later:
  - A=0000, B=0000 -> y=1
  - A=0101, B=0011 -> x=1
  - A=0010, B=1010 -> z=1
  - A=1100, B=1010 -> x=1
  - A=0111, B=0111 -> y=1
  - out_valid is high on every result cycle.
- Signed mode: A=1100 (-4), B=0010 (+2) -> z=1; the same operands with signed_mode=0 -> x=1.
- Cascade: A=B=1001 with gt_in=1 -> x=1; with lt_in=1 -> z=1; with all cascade inputs 0 -> y=1; with gt_in=lt_in=1 -> x=1.
- Hold: drive A=0101, B=0011 with in_valid=1, then change operands with in_valid=0 -> x stays 1 and out_valid drops to 0.
- Exhaustive: all 256 A/B pairs in both modes -> outputs one-hot and matching a behavioural integer compare.
